ssd_multi_score_scan: RTL and testbench

//  Parametrised time-multiplexed seven-segment driver for NUM_CH scores of DIGITS digits each.

---
 rtl/ssd_multi_score_scan.sv | 241 ++++++++++++++++++++++++
 tb/tb_ssd_multi_score_scan.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_multi_score_scan.sv
// Time-multiplexed seven-segment driver for NUM_CH binary scores of DIGITS digits each.
// Scores are converted to BCD one channel at a time by a serial double-dabble engine.
module ssd_multi_score_scan #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned VAL_W      = 16,
    parameter int unsigned PRESCALE_W = 18,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*VAL_W-1:0]  score_in,
    input  logic                     load,
    output logic                     busy,
    output logic [NUM_CH-1:0]        ovf,
    output logic [NUM_CH*DIGITS-1:0] anode,
    output logic [6:0]               ssdOut,
    output logic                     dp
);
    localparam int unsigned TOT   = NUM_CH * DIGITS;
    localparam int unsigned IDX_W = (TOT > 1) ? $clog2(TOT) : 1;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(VAL_W + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {StIdle, StChk, StShift, StStore} state_e;

    state_e                        state_q, state_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [NUM_CH-1:0][VAL_W-1:0]  shadow_q, shadow_d;
    logic [NUM_CH-1:0][VAL_W-1:0]  pend_val_q, pend_val_d;
    logic                          pend_q, pend_d;
    logic [VAL_W-1:0]              val_q, val_d;
    logic [BCD_W-1:0]              bcd_q, bcd_d, bcd_adj;
    logic                          sat_q, sat_d;
    logic [NUM_CH-1:0][DIGITS-1:0][3:0] disp_q, disp_d;
    logic [NUM_CH-1:0]             ovf_q, ovf_d;

    logic [PRESCALE_W-1:0]         presc_q;
    logic [IDX_W-1:0]              idx_q;
    logic [CH_W-1:0]               sch_q;
    logic [DIG_W-1:0]              sdig_q;
    logic [NUM_CH-1:0][DIGITS-1:0] blank_m;
    logic [TOT-1:0]                anode_q, anode_d;
    logic [6:0]                    seg_q, seg_d;
    logic                          dp_q, dp_d;
    logic [DIG_W-1:0]              nib_pos;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        val_d      = val_q;
        bcd_d      = bcd_q;
        sat_d      = sat_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        if (load && state_q != StIdle) begin
            pend_d     = 1'b1;
            pend_val_d = score_in;
        end
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    shadow_d = score_in;
                    pend_d   = 1'b0;
                    ch_d     = '0;
                    state_d  = StChk;
                end else if (pend_q) begin
                    shadow_d = pend_val_q;
                    pend_d   = 1'b0;
                    ch_d     = '0;
                    state_d  = StChk;
                end
            end
            StChk: begin
                if (64'(shadow_q[ch_q]) >= LIMIT) begin
                    sat_d   = 1'b1;
                    state_d = StStore;
                end else begin
                    sat_d   = 1'b0;
                    bcd_d   = '0;
                    val_d   = shadow_q[ch_q];
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                bcd_d = {bcd_adj[BCD_W-2:0], val_q[VAL_W-1]};
                val_d = {val_q[VAL_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(VAL_W - 1)) state_d = StStore;
            end
            StStore: begin
                disp_d[ch_q] = sat_q ? {DIGITS{4'h9}} : bcd_q;
                ovf_d[ch_q]  = sat_q;
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    state_d = StIdle;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = StChk;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ch_q       <= '0;
            cnt_q      <= '0;
            shadow_q   <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            val_q      <= '0;
            bcd_q      <= '0;
            sat_q      <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            val_q      <= val_d;
            bcd_q      <= bcd_d;
            sat_q      <= sat_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
        end
    end

    // Scan position kept as flat index plus channel/digit counters to avoid a divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            sch_q   <= '0;
            sdig_q  <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (&presc_q) begin
                if (idx_q == IDX_W'(TOT - 1)) begin
                    idx_q  <= '0;
                    sch_q  <= '0;
                    sdig_q <= '0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                    if (sdig_q == DIG_W'(DIGITS - 1)) begin
                        sdig_q <= '0;
                        sch_q  <= sch_q + 1'b1;
                    end else begin
                        sdig_q <= sdig_q + 1'b1;
                    end
                end
            end
        end
    end

    // Nibble p (0 = LS) is blank when it and every more-significant nibble are zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank_m  = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            zero_run = 1'b1;
            for (int p = int'(DIGITS) - 1; p >= 1; p--) begin
                zero_run      = zero_run & (disp_q[c][p] == 4'd0);
                blank_m[c][p] = BLANK_LZ & zero_run;
            end
        end
    end

    always_comb begin
        nib_pos = DIG_W'(DIGITS - 1) - sdig_q;
        anode_d = '1;
        if (presc_q != '0) anode_d[IDX_W'(TOT - 1) - idx_q] = 1'b0;
        seg_d   = blank_m[sch_q][nib_pos] ? 7'b1111111 : seg_of(disp_q[sch_q][nib_pos]);
        dp_d    = ~ovf_q[sch_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_q <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign busy   = (state_q != StIdle) | pend_q;
    assign ovf    = ovf_q;
    assign anode  = anode_q;
    assign ssdOut = seg_q;
    assign dp     = dp_q;
endmodule

// File: tb/tb_ssd_multi_score_scan.sv
// Bench for ssd_multi_score_scan: transaction-level reference model compared every cycle,
// plus literal checks of the displayed digits for fixed scores.
module tb_ssd_multi_score_scan;
    localparam int NUM_CH     = 2;
    localparam int DIGITS     = 4;
    localparam int VAL_W      = 16;
    localparam int PRESCALE_W = 2;
    localparam int TOT        = NUM_CH * DIGITS;
    localparam int P          = 1 << PRESCALE_W;
    localparam longint LIM    = longint'(10 ** DIGITS);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic [NUM_CH*VAL_W-1:0] score_in = '0;
    logic                    load = 1'b0;
    logic                    busy;
    logic [NUM_CH-1:0]       ovf;
    logic [TOT-1:0]          anode;
    logic [6:0]              ssdOut;
    logic                    dp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ssd_multi_score_scan #(
        .NUM_CH    (NUM_CH),
        .DIGITS    (DIGITS),
        .VAL_W     (VAL_W),
        .PRESCALE_W(PRESCALE_W),
        .BLANK_LZ  (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .score_in(score_in),
        .load    (load),
        .busy    (busy),
        .ovf     (ovf),
        .anode   (anode),
        .ssdOut  (ssdOut),
        .dp      (dp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_lut(input longint d);
        case (d)
            0: return 7'h01;
            1: return 7'h4F;
            2: return 7'h12;
            3: return 7'h06;
            4: return 7'h4C;
            5: return 7'h24;
            6: return 7'h20;
            7: return 7'h0F;
            8: return 7'h00;
            9: return 7'h04;
            default: return 7'h7F;
        endcase
    endfunction

    // Digit d (0 = MS) of value v, blanked when v has fewer significant digits.
    function automatic logic [6:0] digit_seg(input longint v, input int d);
        longint pw = 1;
        for (int i = 0; i < DIGITS - 1 - d; i++) pw = pw * 10;
        if (d != DIGITS - 1 && v < pw) return 7'h7F;
        return seg_lut((v / pw) % 10);
    endfunction

    // Reference model state
    longint n_edges, job_end;
    longint wr_edge [NUM_CH];
    longint jval [NUM_CH];
    bit     jsat [NUM_CH];
    longint mval [NUM_CH];
    bit     movf [NUM_CH];
    bit     pend;
    logic [NUM_CH*VAL_W-1:0] pval;
    logic [TOT-1:0]    exp_anode = '1;
    logic [6:0]        exp_seg = 7'h7F;
    logic              exp_dp = 1'b1;
    logic              exp_busy = 1'b0;
    logic [NUM_CH-1:0] exp_ovf = '0;

    task automatic model_reset();
        n_edges = 0;
        job_end = 0;
        pend = 0;
        pval = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_edge[c] = 0; jval[c] = 0; jsat[c] = 0; mval[c] = 0; movf[c] = 0;
        end
        exp_anode = '1; exp_seg = 7'h7F; exp_dp = 1'b1; exp_busy = 1'b0; exp_ovf = '0;
    endtask

    task automatic start_job(input logic [NUM_CH*VAL_W-1:0] v);
        longint t = n_edges;
        longint x;
        bit sat;
        for (int c = 0; c < NUM_CH; c++) begin
            x = longint'(v[c*VAL_W +: VAL_W]);
            sat = (x >= LIM);
            t = t + (sat ? 2 : VAL_W + 2);
            wr_edge[c] = t;
            jval[c] = sat ? LIM - 1 : x;
            jsat[c] = sat;
        end
        job_end = t;
        pend = 0;
    endtask

    task automatic model_step();
        int pr, ix, ch, dg;
        pr = int'(n_edges % P);
        ix = int'((n_edges / P) % TOT);
        ch = ix / DIGITS;
        dg = ix % DIGITS;
        exp_anode = '1;
        if (pr != 0) exp_anode[TOT-1-ix] = 1'b0;
        exp_seg = digit_seg(mval[ch], dg);
        exp_dp = !movf[ch];
        n_edges++;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_edge[c] == n_edges) begin
                mval[c] = jval[c];
                movf[c] = jsat[c];
            end
        end
        if (n_edges <= job_end) begin
            if (load) begin
                pend = 1;
                pval = score_in;
            end
        end else if (load) begin
            start_job(score_in);
        end else if (pend) begin
            start_job(pval);
        end
        exp_busy = (n_edges < job_end) || pend;
        for (int c = 0; c < NUM_CH; c++) exp_ovf[c] = movf[c];
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("anode", anode, exp_anode);
            chk("busy", busy, exp_busy);
            chk("ovf", ovf, exp_ovf);
            chk("one_anode_low", ($countones(~anode) <= 1), 1);
            if (exp_anode != '1) begin
                chk("ssdOut", ssdOut, exp_seg);
                chk("dp", dp, exp_dp);
            end
        end
    end

    logic [6:0] obs_seg [TOT];
    logic       obs_dp [TOT];

    task automatic capture_frame();
        for (int i = 0; i < TOT; i++) begin
            obs_seg[i] = 7'h55;
            obs_dp[i] = 1'b0;
        end
        repeat (TOT * P + 2) begin
            @(negedge clk);
            for (int b = 0; b < TOT; b++) begin
                if (anode[b] == 1'b0) begin
                    obs_seg[TOT-1-b] = ssdOut;
                    obs_dp[TOT-1-b] = dp;
                end
            end
        end
    endtask

    task automatic do_load(input logic [NUM_CH*VAL_W-1:0] v);
        @(negedge clk);
        score_in = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        chk("idle_timeout", busy, 0);
    endtask

    function automatic logic [15:0] rand_score();
        case ($urandom_range(0, 3))
            0: return 16'($urandom_range(0, 99));
            1: return 16'($urandom_range(0, 9999));
            2: return 16'($urandom_range(10000, 65535));
            default: return 16'($urandom_range(9990, 10009));
        endcase
    endfunction

    initial begin
        int cnt;
        int busy_cnt;
        bit seen7, saw5;
        logic [6:0] lit2 [TOT];
        lit2 = '{7'h4F, 7'h12, 7'h06, 7'h4C, 7'h7F, 7'h7F, 7'h4C, 7'h12};

        #1 rst_n = 1'b0;
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset display: only the LS digit of each channel shows "0"
        capture_frame();
        for (int i = 0; i < TOT; i++) begin
            chk("t1_seg", obs_seg[i], (i % DIGITS == DIGITS - 1) ? 7'h01 : 7'h7F);
            chk("t1_dp", obs_dp[i], 1);
        end

        // ch1=42, ch0=1234
        do_load({16'd42, 16'd1234});
        wait_idle(cnt);
        chk("t2_busy_len", cnt, 36);
        chk("t2_model_ch0", mval[0], 1234);
        chk("t2_model_ch1", mval[1], 42);
        capture_frame();
        for (int i = 0; i < TOT; i++) chk("t2_seg", obs_seg[i], lit2[i]);

        // ch0 overflow saturates to 9999
        do_load({16'd42, 16'd10000});
        wait_idle(cnt);
        chk("t3_busy_len", cnt, 20);
        chk("t3_ovf", ovf, 2'b01);
        capture_frame();
        for (int i = 0; i < TOT; i++) begin
            chk("t3_seg", obs_seg[i], (i < DIGITS) ? 7'h04 : lit2[i]);
            chk("t3_dp", obs_dp[i], (i < DIGITS) ? 0 : 1);
        end

        // 5, then 7 and 9 while busy: 7 is overwritten by 9
        busy_cnt = 0; seen7 = 0; saw5 = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (anode[TOT-DIGITS] == 1'b0) begin
                if (ssdOut == 7'h0F) seen7 = 1;
                if (ssdOut == 7'h24) saw5 = 1;
            end
            load = (k == 0 || k == 5 || k == 10);
            score_in = {16'd0, (k == 0) ? 16'd5 : (k == 5) ? 16'd7 : 16'd9};
        end
        load = 1'b0;
        wait_idle(cnt);
        chk("t4_busy_len", busy_cnt, 73);
        chk("t4_seen7", seen7, 0);
        chk("t4_saw5", saw5, 1);
        chk("t4_ovf", ovf, 2'b00);
        capture_frame();
        for (int i = 0; i < DIGITS; i++) chk("t4_seg", obs_seg[i], (i == DIGITS - 1) ? 7'h04 : 7'h7F);
        chk("t4_seg_ch1", obs_seg[TOT-1], 7'h01);

        // Reset in the middle of the shift phase
        do_load({16'd777, 16'd4321});
        repeat (8) @(negedge clk);
        chk("t5_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_anode", anode, {TOT{1'b1}});
        chk("t5_busy", busy, 0);
        chk("t5_ovf", ovf, 0);
        chk("t5_ssd", ssdOut, 7'h7F);
        chk("t5_dp", dp, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        capture_frame();
        for (int i = 0; i < TOT; i++)
            chk("t5_seg", obs_seg[i], (i % DIGITS == DIGITS - 1) ? 7'h01 : 7'h7F);

        // Random loads, including loads while busy and near the saturation boundary
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            load = ($urandom_range(0, 24) == 0);
            for (int c = 0; c < NUM_CH; c++) score_in[c*VAL_W +: VAL_W] = rand_score();
        end
        @(negedge clk);
        load = 1'b0;
        wait_idle(cnt);
        capture_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
